memory_rw: RTL and testbench
============================

// Module: memory_rw
// PURPOSE
//  Single-port synchronous RAM slave with a valid/ready request handshake.
//  - Serves one read or write per request, with a registered one-cycle response.
//  - Sits behind the mem_intf interface; the agent/BFM drives requests and samples responses.
// PARAMETERS
//  ADDR_WIDTH  16              address bits (word addressed)
//  DATA_WIDTH  32              data word width
//  DEPTH       2**ADDR_WIDTH   number of words; every addr_i value is in range
// PORTS
//  clk_i    in   1           single clock; all state updates on rising edge
//  rst_i    in   1           reset, asynchronous assert, active-low
//  valid_i  in   1           request valid
//  wr_rd_i  in   1           1 = write, 0 = read; sampled with valid_i
//  addr_i   in   ADDR_WIDTH  word address; sampled with valid_i
//  wdata_i  in   DATA_WIDTH  write data; sampled with valid_i when wr_rd_i=1
//  rdata_o  out  DATA_WIDTH  read data, registered
//  ready_o  out  1           response strobe, registered, one-cycle pulse
// BEHAVIOUR
//  - Reset (rst_i=0), applied immediately: ready_o=0, rdata_o=0, FSM=IDLE.
//    - Array contents are not reset; reading a never-written word is undefined (X in simulation).
//  - FSM states: IDLE, RESP.
//  - IDLE, rising edge with valid_i=1: request accepted; go to RESP; ready_o<=1.
//    - Write: mem[addr_i]<=wdata_i on that edge; rdata_o unchanged.
//    - Read: rdata_o<=mem[addr_i] on that edge.
//  - IDLE, rising edge with valid_i=0: stay in IDLE; ready_o<=0.
//  - RESP: ready_o=1 for exactly one cycle; valid_i ignored; next edge -> IDLE, ready_o<=0.
//  - Latency: request accepted at edge N; ready_o high and rdata_o valid from edge N to edge N+1.
//  - Master protocol: hold valid_i/wr_rd_i/addr_i/wdata_i stable until ready_o=1, then drop valid_i or present the next request.
//    - Maximum throughput is one transaction per 2 cycles.
//  - If valid_i is still 1 in the cycle after RESP, it is a new request.
//  - rdata_o holds the last read value through writes and idle cycles, until the next read or reset.
//  - Read-after-write to the same address in a later transaction returns the new data.
//    - No same-edge read/write hazard exists, because the port is single.
//  - Reset mid-transaction:
//    - A write committed on an edge before reset assertion stays committed.
//    - ready_o drops immediately; no response is issued after reset release.
//  - Address wrap: none; all 2**ADDR_WIDTH addresses are valid, including 0 and 16'hFFFF.
//  - X or Z on valid_i after reset: treated as 0 (no access).
// STRUCTURE
//  - Package mem_pkg:
//    - ADDR_WIDTH and DATA_WIDTH defaults
//    - typedefs addr_t, data_t
//    - enum state_e {IDLE, RESP}
//  - Sub-module mem_array: DEPTH x DATA_WIDTH storage with synchronous write and registered read, one port.
//  - memory_rw holds the FSM, the ready_o register and the enables to mem_array.
// TESTING
//  - Reset: hold rst_i=0 for 2 cycles -> ready_o=0, rdata_o=0; after release with valid_i=0 ready_o stays 0.
//  - Write then read: write 32'hDEADBEEF to 16'h0010, then read 16'h0010 -> ready_o pulses 1 cycle each; rdata_o=32'hDEADBEEF.
//  - Boundaries: write 32'hA5A5A5A5 to 16'h0000 and 32'h5A5A5A5A to 16'hFFFF; read both -> values returned exactly, no aliasing.
//  - Handshake: hold valid_i=1 (read) for 3 cycles -> ready_o high on alternate cycles (two transactions); never high two cycles in a row.
//  - Overwrite/hold: write 1 then 2 to 16'h0042; read -> 2; then write 16'h0001 with value 7 -> rdata_o stays 2.
//  - Reset mid-transaction: write 16'h0005=32'h1234_5678, pulse rst_i low during RESP -> ready_o drops at once; post-reset read of 16'h0005 returns 32'h12345678.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, word types and FSM state encoding for the memory_rw slave.
package mem_pkg;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;

  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;
endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read; contents are never reset.
// Only the read-data register is reset, so rdata_o holds its value across writes.
module mem_array #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !we_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/memory_rw.sv
// Single-port RAM slave with valid/ready handshake: one access per request,
// ready_o pulses one cycle after acceptance, so throughput is one access per two cycles.
module memory_rw
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o
);
  state_e state_q, state_d;
  logic   ready_q, ready_d;
  logic   mem_en;

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    mem_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = RESP;
          ready_d = 1'b1;
          mem_en  = 1'b1;
        end
      end
      // The response cycle ignores valid_i; a held request is re-accepted next cycle.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (mem_en),
    .we_i   (wr_rd_i),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o)
  );

  assign ready_o = ready_q;
endmodule

// File: tb/tb_memory_rw.sv
// Directed vector bench for memory_rw: per-cycle request table plus a reset-mid-transaction sequence.
module tb_memory_rw;
  import mem_pkg::*;

  logic  clk_i;
  logic  rst_i;
  logic  valid_i;
  logic  wr_rd_i;
  addr_t addr_i;
  data_t wdata_i;
  data_t rdata_o;
  logic  ready_o;

  int checks;
  int errors;

  typedef struct {
    string name;
    logic  valid;
    logic  wr;
    addr_t addr;
    data_t wdata;
    logic  exp_ready;
    data_t exp_rdata;
  } vec_t;

  vec_t vecs[$];

  memory_rw dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .wr_rd_i(wr_rd_i),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o),
    .ready_o(ready_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic v, input logic w, input addr_t a,
                     input data_t d, input logic er, input data_t ed);
    vec_t t;
    t.name = name; t.valid = v; t.wr = w; t.addr = a; t.wdata = d;
    t.exp_ready = er; t.exp_rdata = ed;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic w, input addr_t a, input data_t d);
    @(negedge clk_i);
    valid_i = v;
    wr_rd_i = w;
    addr_i  = a;
    wdata_i = d;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    wr_rd_i = 1'b0;
    addr_i  = '0;
    wdata_i = '0;

    // write then read
    add("wr_0010",      1, 1, 16'h0010, 32'hDEADBEEF, 1, 32'h0);
    add("idle_a",       0, 0, 16'h0000, 32'h0,        0, 32'h0);
    add("rd_0010",      1, 0, 16'h0010, 32'h0,        1, 32'hDEADBEEF);
    add("idle_b",       0, 0, 16'h0000, 32'h0,        0, 32'hDEADBEEF);
    // address boundaries
    add("wr_0000",      1, 1, 16'h0000, 32'hA5A5A5A5, 1, 32'hDEADBEEF);
    add("idle_c",       0, 0, 16'h0000, 32'h0,        0, 32'hDEADBEEF);
    add("wr_ffff",      1, 1, 16'hFFFF, 32'h5A5A5A5A, 1, 32'hDEADBEEF);
    add("idle_d",       0, 0, 16'h0000, 32'h0,        0, 32'hDEADBEEF);
    add("rd_0000",      1, 0, 16'h0000, 32'h0,        1, 32'hA5A5A5A5);
    add("idle_e",       0, 0, 16'h0000, 32'h0,        0, 32'hA5A5A5A5);
    add("rd_ffff",      1, 0, 16'hFFFF, 32'h0,        1, 32'h5A5A5A5A);
    add("idle_f",       0, 0, 16'h0000, 32'h0,        0, 32'h5A5A5A5A);
    // valid held three cycles: two transactions, ready alternates
    add("hold_rd_1",    1, 0, 16'h0000, 32'h0,        1, 32'hA5A5A5A5);
    add("hold_rd_2",    1, 0, 16'h0000, 32'h0,        0, 32'hA5A5A5A5);
    add("hold_rd_3",    1, 0, 16'h0000, 32'h0,        1, 32'hA5A5A5A5);
    add("idle_g",       0, 0, 16'h0000, 32'h0,        0, 32'hA5A5A5A5);
    // overwrite, then rdata holds through an unrelated write
    add("wr_0042_1",    1, 1, 16'h0042, 32'h1,        1, 32'hA5A5A5A5);
    add("idle_h",       0, 0, 16'h0000, 32'h0,        0, 32'hA5A5A5A5);
    add("wr_0042_2",    1, 1, 16'h0042, 32'h2,        1, 32'hA5A5A5A5);
    add("idle_i",       0, 0, 16'h0000, 32'h0,        0, 32'hA5A5A5A5);
    add("rd_0042",      1, 0, 16'h0042, 32'h0,        1, 32'h2);
    add("idle_j",       0, 0, 16'h0000, 32'h0,        0, 32'h2);
    add("wr_0001_7",    1, 1, 16'h0001, 32'h7,        1, 32'h2);
    add("idle_k",       0, 0, 16'h0000, 32'h0,        0, 32'h2);
    add("rd_0001",      1, 0, 16'h0001, 32'h0,        1, 32'h7);
    add("idle_l",       0, 0, 16'h0000, 32'h0,        0, 32'h7);

    // reset held for two cycles
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", {31'b0, ready_o}, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #1;
      check("post_rst_idle_ready", {31'b0, ready_o}, 32'h0);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      @(posedge clk_i);
      #1;
      check({vecs[i].name, "_ready"}, {31'b0, ready_o}, {31'b0, vecs[i].exp_ready});
      check({vecs[i].name, "_rdata"}, rdata_o, vecs[i].exp_rdata);
    end

    // reset asserted during the response cycle of a write
    drive(1, 1, 16'h0005, 32'h12345678);
    @(posedge clk_i);
    #1;
    check("mid_wr_ready", {31'b0, ready_o}, 32'h1);
    valid_i = 1'b0;
    wr_rd_i = 1'b0;
    #1;
    rst_i = 1'b0;
    #1;
    check("mid_rst_ready_drop", {31'b0, ready_o}, 32'h0);
    check("mid_rst_rdata", rdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #1;
      check("mid_rst_no_resp", {31'b0, ready_o}, 32'h0);
    end
    drive(1, 0, 16'h0005, 32'h0);
    @(posedge clk_i);
    #1;
    check("post_rst_rd_ready", {31'b0, ready_o}, 32'h1);
    check("post_rst_rd_rdata", rdata_o, 32'h12345678);
    drive(0, 0, 16'h0000, 32'h0);
    @(posedge clk_i);
    #1;
    check("post_rst_rd_done", {31'b0, ready_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
